// File: rtl/cnt_updn_mod.sv
// cnt_updn_mod
// General-purpose up/down counter used as timebase, event counter and
// frame/sample counter. Counts over 0..limit, either wrapping or saturating
// at the ends, with parallel load and an enable prescaler.
//
// Parameters:
//   WIDTH    counter width (2..32)
//   PW       prescaler width (1..16)
// Ports:
//   clk      module clock, rising edge
//   rst      asynchronous reset, active-high
//   srst     synchronous reset, active-high
//   ena      count enable
//   load     synchronous parallel load (load_val -> dout)
//   load_val value written on load
//   dir      1 = count up, 0 = count down
//   sat      1 = saturate at the boundary, 0 = wrap
//   limit    terminal value, count range is 0..limit
//   presc    one step per presc+1 enabled cycles
//   clr_ovf  clears the sticky overflow flag
//   dout     counter value (registered)
//   tc       one-cycle boundary-event pulse (registered)
//   ovf      sticky boundary-event flag (registered)
//   at_max   dout >= limit (combinational)
//   at_min   dout == 0 (combinational)
module cnt_updn_mod #(
  parameter int WIDTH = 16,
  parameter int PW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             srst,
  input  logic             ena,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  input  logic [PW-1:0]    presc,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  logic [PW-1:0]    pcnt;
  logic             step;
  logic             bnd_evt;
  logic [WIDTH-1:0] dout_nxt;

  // A step happens only when the prescale phase is complete. If presc was
  // lowered below pcnt, pcnt simply runs through all-ones and back around.
  assign step = ena && (pcnt == presc);

  // Next value for a qualified step. Using >= / != 0 as the in-range test
  // makes a dout that was loaded above limit behave as "at the top" when
  // counting up, while counting down from it still just decrements.
  always_comb begin
    dout_nxt = dout;
    bnd_evt  = 1'b0;
    if (dir) begin
      if (dout < limit) begin
        dout_nxt = dout + 1'b1;
      end else begin
        bnd_evt  = 1'b1;
        dout_nxt = sat ? limit : '0;
      end
    end else begin
      if (dout != '0) begin
        dout_nxt = dout - 1'b1;
      end else begin
        bnd_evt  = 1'b1;
        dout_nxt = sat ? '0 : limit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      pcnt <= '0;
      tc   <= 1'b0;
      ovf  <= 1'b0;
    end else if (srst) begin
      dout <= '0;
      pcnt <= '0;
      tc   <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      dout <= load_val;
      pcnt <= '0;
      tc   <= 1'b0;
      if (clr_ovf) ovf <= 1'b0;
    end else begin
      tc <= 1'b0;
      // Clear first so that a boundary event in the same cycle overrides it.
      if (clr_ovf) ovf <= 1'b0;
      if (ena) begin
        if (step) begin
          pcnt <= '0;
          dout <= dout_nxt;
          if (bnd_evt) begin
            tc  <= 1'b1;
            ovf <= 1'b1;
          end
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end
    end
  end

  assign at_max = (dout >= limit);
  assign at_min = (dout == '0);

endmodule

// File: tb/tb_cnt_updn_mod.sv
// Directed bench for cnt_updn_mod (WIDTH=8, PW=4). The driver pushes the
// expected post-edge state after each edge; the monitor pops and compares
// on the following falling edge.
module tb_cnt_updn_mod;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk;
  logic          rst;
  logic          srst;
  logic          ena;
  logic          load;
  logic [W-1:0]  load_val;
  logic          dir;
  logic          sat;
  logic [W-1:0]  limit;
  logic [PW-1:0] presc;
  logic          clr_ovf;
  logic [W-1:0]  dout;
  logic          tc;
  logic          ovf;
  logic          at_max;
  logic          at_min;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        nm;
    logic [W-1:0] d;
    logic         t;
    logic         o;
    logic [W-1:0] lim;
  } exp_t;

  exp_t exp_q[$];

  cnt_updn_mod #(.WIDTH(W), .PW(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .srst     (srst),
    .ena      (ena),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .sat      (sat),
    .limit    (limit),
    .presc    (presc),
    .clr_ovf  (clr_ovf),
    .dout     (dout),
    .tc       (tc),
    .ovf      (ovf),
    .at_max   (at_max),
    .at_min   (at_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string nm, input logic [W-1:0] ed,
                          input logic et, input logic eo);
    exp_t e;
    e.nm  = nm;
    e.d   = ed;
    e.t   = et;
    e.o   = eo;
    e.lim = limit;
    exp_q.push_back(e);
  endtask

  // Called at negedge+1 with inputs already set; returns at next negedge+1.
  task automatic cyc(input string nm, input logic [W-1:0] ed,
                     input logic et, input logic eo);
    @(posedge clk);
    push_exp(nm, ed, et, eo);
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    logic xmax;
    logic xmin;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        xmax = (e.d >= e.lim);
        xmin = (e.d == '0);
        checks++;
        if ({dout, tc, ovf, at_max, at_min} !== {e.d, e.t, e.o, xmax, xmin}) begin
          failures++;
          $display("FAIL %s: got dout=%h tc=%b ovf=%b at_max=%b at_min=%b expected dout=%h tc=%b ovf=%b at_max=%b at_min=%b",
                   e.nm, dout, tc, ovf, at_max, at_min, e.d, e.t, e.o, xmax, xmin);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; srst = 1'b0; ena = 1'b0; load = 1'b0; load_val = '0;
    dir = 1'b1; sat = 1'b0; limit = 8'd5; presc = '0; clr_ovf = 1'b0;
    push_exp("reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;

    // up wrap
    limit = 8'd9; presc = '0; dir = 1'b1; sat = 1'b0; ena = 1'b1;
    for (int i = 1; i <= 9; i++) cyc("upwrap_cnt", W'(i), 1'b0, 1'b0);
    cyc("upwrap_tc", 8'd0, 1'b1, 1'b1);
    cyc("upwrap_after", 8'd1, 1'b0, 1'b1);

    // down saturate
    load = 1'b1; load_val = 8'd2; clr_ovf = 1'b1; dir = 1'b0; sat = 1'b1;
    cyc("dsat_load", 8'd2, 1'b0, 1'b0);
    load = 1'b0; clr_ovf = 1'b0;
    cyc("dsat_1", 8'd1, 1'b0, 1'b0);
    cyc("dsat_0", 8'd0, 1'b0, 1'b0);
    cyc("dsat_hold", 8'd0, 1'b1, 1'b1);
    clr_ovf = 1'b1;
    cyc("dsat_clr_vs_set", 8'd0, 1'b1, 1'b1);
    ena = 1'b0;
    cyc("dsat_clr", 8'd0, 1'b0, 1'b0);
    clr_ovf = 1'b0;

    // prescaler
    srst = 1'b1;
    cyc("pre_srst", 8'd0, 1'b0, 1'b0);
    srst = 1'b0; presc = 4'd3; dir = 1'b1; sat = 1'b0; limit = 8'hFF; ena = 1'b1;
    for (int i = 0; i < 3; i++) cyc("pre_wait", 8'd0, 1'b0, 1'b0);
    cyc("pre_step1", 8'd1, 1'b0, 1'b0);
    cyc("pre_ph1", 8'd1, 1'b0, 1'b0);
    cyc("pre_ph2", 8'd1, 1'b0, 1'b0);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) cyc("pre_pause", 8'd1, 1'b0, 1'b0);
    ena = 1'b1;
    cyc("pre_ph3", 8'd1, 1'b0, 1'b0);
    cyc("pre_step2", 8'd2, 1'b0, 1'b0);
    cyc("pre_ph1b", 8'd2, 1'b0, 1'b0);
    load = 1'b1; load_val = 8'h10;
    cyc("pre_load", 8'h10, 1'b0, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) cyc("pre_restart", 8'h10, 1'b0, 1'b0);
    cyc("pre_step3", 8'h11, 1'b0, 1'b0);

    // priority
    srst = 1'b1; load = 1'b1; load_val = 8'h55; ena = 1'b1;
    cyc("prio_srst", 8'd0, 1'b0, 1'b0);
    srst = 1'b0; presc = '0;
    cyc("prio_load", 8'h55, 1'b0, 1'b0);

    // limit change below current value
    load_val = 8'd20; limit = 8'd10; ena = 1'b0; dir = 1'b1; sat = 1'b0;
    cyc("lim_load", 8'd20, 1'b0, 1'b0);
    load = 1'b0; ena = 1'b1;
    cyc("lim_upwrap", 8'd0, 1'b1, 1'b1);
    load = 1'b1; clr_ovf = 1'b1; ena = 1'b0;
    cyc("lim_load2", 8'd20, 1'b0, 1'b0);
    load = 1'b0; clr_ovf = 1'b0; dir = 1'b0; ena = 1'b1;
    cyc("lim_down", 8'd19, 1'b0, 1'b0);
    load = 1'b1; ena = 1'b0; sat = 1'b1; dir = 1'b1;
    cyc("lim_load3", 8'd20, 1'b0, 1'b0);
    load = 1'b0; ena = 1'b1;
    cyc("lim_upsat", 8'd10, 1'b1, 1'b1);

    // limit zero, down wrap
    srst = 1'b1;
    cyc("l0_srst", 8'd0, 1'b0, 1'b0);
    srst = 1'b0; limit = 8'd0; sat = 1'b0; dir = 1'b1;
    for (int i = 0; i < 3; i++) cyc("l0_tc", 8'd0, 1'b1, 1'b1);
    srst = 1'b1; limit = 8'd5;
    cyc("dw_srst", 8'd0, 1'b0, 1'b0);
    srst = 1'b0; dir = 1'b0;
    cyc("dw_wrap", 8'd5, 1'b1, 1'b1);
    dir = 1'b1;
    cyc("uw_wrap", 8'd0, 1'b1, 1'b1);

    // async reset mid-cycle
    load = 1'b1; load_val = 8'h37; ena = 1'b0;
    cyc("ar_load", 8'h37, 1'b0, 1'b1);
    load = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    push_exp("ar_async", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    limit = 8'hFF; ena = 1'b1; dir = 1'b1; presc = '0;
    cyc("ar_resume1", 8'd1, 1'b0, 1'b0);
    cyc("ar_resume2", 8'd2, 1'b0, 1'b0);
    cyc("ar_resume3", 8'd3, 1'b0, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
